// File: rtl/out_buff.sv
// out_buff: captures 32-bit FPU results and sends each one MSB-first as byte transfers to the UART.
// Define OUT_BUFF_HEADER_EN to put HEADER_BYTE in front of every frame.
module out_buff #(
  parameter int         NUM_BYTES   = 4,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] res_data,
  input  logic        res_valid,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  bulbs
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

`ifdef OUT_BUFF_HEADER_EN
  localparam logic [2:0] LAST = 3'(NUM_BYTES);
`else
  localparam logic [2:0] LAST = 3'(NUM_BYTES - 1);
  logic [7:0] w_unused_hdr;
  assign w_unused_hdr = HEADER_BYTE;
`endif

  state_t      r_state, w_state_n;
  logic [31:0] r_sh, w_sh_n;
  logic [31:0] r_pend, w_pend_n;
  logic        r_pv, w_pv_n;
  logic [2:0]  r_cnt, w_cnt_n;
  logic        r_start, w_start_n;
  logic [7:0]  r_data, w_data_n;
  logic [7:0]  r_bulbs, w_bulbs_n;
  logic        r_ovf, w_ovf_n;
  logic [7:0]  w_cur;
  logic        w_load_new;
  logic        w_shift;

`ifdef OUT_BUFF_HEADER_EN
  // The header occupies slot 0; sh only starts shifting after slot 1
  assign w_cur   = (r_cnt == 3'd0) ? HEADER_BYTE : r_sh[31:24];
  assign w_shift = (r_cnt != 3'd0);
`else
  assign w_cur   = r_sh[31:24];
  assign w_shift = 1'b1;
`endif

  assign w_load_new = (r_state == IDLE) && !r_pv && res_valid;

  always_comb begin
    w_state_n = r_state;
    w_sh_n    = r_sh;
    w_pend_n  = r_pend;
    w_pv_n    = r_pv;
    w_cnt_n   = r_cnt;
    w_start_n = 1'b0;
    w_data_n  = r_data;
    w_bulbs_n = r_bulbs;
    w_ovf_n   = r_ovf;
    unique case (r_state)
      IDLE: begin
        if (r_pv) begin
          w_sh_n    = r_pend;
          w_pv_n    = 1'b0;
          w_cnt_n   = 3'd0;
          w_state_n = SEND;
        end else if (res_valid) begin
          w_sh_n    = res_data;
          w_cnt_n   = 3'd0;
          w_state_n = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          w_start_n = 1'b1;
          w_data_n  = w_cur;
          w_bulbs_n = w_cur;
          w_state_n = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) w_state_n = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (r_cnt == LAST) begin
            w_state_n = IDLE;
          end else begin
            w_cnt_n   = r_cnt + 3'd1;
            if (w_shift) w_sh_n = {r_sh[23:0], 8'h00};
            w_state_n = SEND;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
    // A slot freed by IDLE this cycle can take the new result at once
    if (res_valid && !w_load_new) begin
      if (!w_pv_n) begin
        w_pend_n = res_data;
        w_pv_n   = 1'b1;
      end else begin
        w_ovf_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_pend  <= '0;
      r_pv    <= 1'b0;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_data  <= '0;
      r_bulbs <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sh    <= w_sh_n;
      r_pend  <= w_pend_n;
      r_pv    <= w_pv_n;
      r_cnt   <= w_cnt_n;
      r_start <= w_start_n;
      r_data  <= w_data_n;
      r_bulbs <= w_bulbs_n;
      r_ovf   <= w_ovf_n;
    end
  end

  assign tx_start = r_start;
  assign tx_data  = r_data;
  assign bulbs    = r_bulbs;
  assign overflow = r_ovf;
  assign busy     = (r_state != IDLE) || r_pv;

endmodule

// File: tb/tb_out_buff.sv
// Directed bench for out_buff with a UART model that acknowledges each byte for 10 cycles.
// Expected frames are built from the result words and include the A5 header when OUT_BUFF_HEADER_EN is set.
module tb_out_buff;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] res_data = '0;
  logic        res_valid = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        overflow;
  logic [7:0]  bulbs;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  bit uart_hold = 1'b0;
  bit arm = 1'b0;
  int ucnt = 0;

  always #5 clk = ~clk;

  out_buff dut (
    .clk(clk), .rst(rst), .res_data(res_data), .res_valid(res_valid),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .overflow(overflow), .bulbs(bulbs)
  );

  always @(negedge clk) begin
    if (tx_start) got.push_back(tx_data);
  end

  // UART: busy rises one cycle after tx_start and stays high for 10 cycles
  always @(negedge clk) begin
    if (tx_start) arm = 1'b1;
    else if (arm) begin
      arm = 1'b0;
      ucnt = 10;
    end
    tx_busy = uart_hold || (ucnt != 0);
    if (ucnt != 0) ucnt--;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [31:0] d);
    @(negedge clk);
    res_data = d;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic add_frame(input logic [31:0] w);
`ifdef OUT_BUFF_HEADER_EN
    exp_q.push_back(8'hA5);
`endif
    for (int i = 0; i < 4; i++) exp_q.push_back(w[31-8*i -: 8]);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while ((busy || tx_busy || ucnt != 0 || arm) && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic check_frames(input string tag);
    int m;
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] first;
`ifdef OUT_BUFF_HEADER_EN
    first = 8'hA5;
`else
    first = 8'h3F;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_bulbs", 32'(bulbs), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single frame with latency check
    @(negedge clk);
    res_data = 32'h3FC00000;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    #1;
    check("lat_one_edge", 32'(tx_start), 32'd0);
    check("lat_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check("lat_two_edges", 32'(tx_start), 32'd1);
    check("lat_first_byte", 32'(tx_data), 32'(first));
    add_frame(32'h3FC00000);
    wait_idle("single");
    check_frames("single");
    check("single_bulbs", 32'(bulbs), 32'h00);
    check("single_busy", 32'(busy), 32'd0);

    // Busy stall
    uart_hold = 1'b1;
    repeat (50) @(negedge clk);
    pulse(32'hDEADBEEF);
    repeat (20) @(negedge clk);
    #1;
    check("stall_no_start", 32'(got.size()), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    uart_hold = 1'b0;
    add_frame(32'hDEADBEEF);
    wait_idle("stall");
    check_frames("stall");

    // Back-to-back results
    @(negedge clk);
    res_data = 32'h40490FDB;
    res_valid = 1'b1;
    @(negedge clk);
    res_data = 32'hC0000000;
    @(negedge clk);
    res_valid = 1'b0;
    add_frame(32'h40490FDB);
    add_frame(32'hC0000000);
    wait_idle("b2b");
    check_frames("b2b");
    check("b2b_overflow", 32'(overflow), 32'd0);

    // Overflow: third result is dropped
    @(negedge clk);
    res_data = 32'd1;
    res_valid = 1'b1;
    @(negedge clk);
    res_data = 32'd2;
    @(negedge clk);
    res_data = 32'd3;
    @(negedge clk);
    res_valid = 1'b0;
    #1;
    check("ovf_flag", 32'(overflow), 32'd1);
    add_frame(32'd1);
    add_frame(32'd2);
    wait_idle("ovf");
    check_frames("ovf");
    repeat (5) @(negedge clk);
    #1;
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset after the second byte of a frame
    pulse(32'h12345678);
    begin
      int n;
      n = 0;
      while (got.size() < 2 && n < 500) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("mid_reach_second", 32'(got.size()), 32'd2);
    end
    check("mid_start_before_rst", 32'(tx_start), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_start", 32'(tx_start), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_bulbs", 32'(bulbs), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_idle("mid_drain");
    got.delete();
    exp_q.delete();
    pulse(32'hAABBCCDD);
    add_frame(32'hAABBCCDD);
    wait_idle("after_rst");
    check_frames("after_rst");
    check("after_rst_overflow", 32'(overflow), 32'd0);

    // Frame used for the header build
    pulse(32'h3F800000);
    add_frame(32'h3F800000);
    wait_idle("hdr");
    check_frames("hdr");
    check("hdr_bulbs", 32'(bulbs), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
